wallace_mult_pipe: RTL and testbench

Parametrised, fully pipelined Wallace-tree multiplier. Successor to the fixed 16x16 unsigned four-stage multiplier.
- Adds configurable operand width.
- Adds per-operation signed/unsigned mode.
- Adds valid/ready flow control with back-pressure and a pass-through tag.
- Sits between operand-issuing datapath logic and downstream consumers (MAC/filter blocks).

---
 rtl/wallace_pkg.sv | 48 ++++
 rtl/wallace_csa_row.sv | 18 +
 rtl/wallace_mult_pipe.sv | 163 ++++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared constants, stage control struct and tree-sizing helpers for wallace_mult_pipe.
package wallace_pkg;

  localparam int LATENCY = 4;
  localparam int TAG_MAX = 32;

  // Tags are carried zero-extended to TAG_MAX; the top slices back to its TAG_W.
  typedef struct packed {
    logic               valid;
    logic               clr;
    logic [TAG_MAX-1:0] tag;
  } stage_ctl_t;

  function automatic int rows_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_after(input int n, input int levels);
    int r;
    r = n;
    for (int i = 0; i < levels; i++) r = rows_next(r);
    return r;
  endfunction

  function automatic int levels_to3(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int i = 0; i < 16; i++) begin
      if (r > 3) begin
        r = rows_next(r);
        l++;
      end
    end
    return l;
  endfunction

  // Modified Baugh-Wooley constant: +2^W + 2^(2W-1), exact modulo 2^(2W).
  function automatic logic [63:0] bw_correction(input int width);
    logic [63:0] k;
    k = '0;
    k[width] = 1'b1;
    k[2*width-1] = 1'b1;
    return k;
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// 3:2 carry-save row: bitwise sum plus majority carry shifted up one bit (top carry discarded).
module wallace_csa_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-2:0] maj;

  assign sum   = x ^ y ^ z;
  assign maj   = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
  assign carry = {maj, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Four-stage pipelined Wallace-tree multiplier, signed/unsigned per beat, valid/ready with tag.
// Define WALLACE_ACC_EN to turn the final stage into a wrapping accumulator.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int P  = 2 * WIDTH;
  localparam int N0 = WIDTH + 1;
  localparam int N1 = rows_next(N0);
  localparam int L2 = levels_to3(N1);
  localparam logic [63:0]  BW_K64 = bw_correction(WIDTH);
  localparam logic [P-1:0] BW_K   = BW_K64[P-1:0];

  logic stall;
  logic adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  stage_ctl_t s1_ctl_d, s1_ctl, s2_ctl, s3_ctl;

  always_comb begin
    s1_ctl_d = '0;
    s1_ctl_d.valid = in_valid;
    s1_ctl_d.clr = acc_clr;
    s1_ctl_d.tag[TAG_W-1:0] = in_tag;
  end

  // S1: partial products; cross terms with exactly one MSB operand bit are inverted in signed mode.
  logic [P-1:0] pp [N0];
  always_comb begin
    for (int i = 0; i < N0; i++) pp[i] = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        pp[i][i+j] = (in_a[j] & in_b[i]) ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
    pp[N0-1] = in_signed ? BW_K : '0;
  end

  logic [P-1:0] s1_d    [N1];
  logic [P-1:0] s1_rows [N1];

  for (genvar g = 0; g < N0/3; g++) begin : g_l1
    wallace_csa_row #(.W(P)) u_csa (
      .x(pp[3*g]), .y(pp[3*g+1]), .z(pp[3*g+2]),
      .sum(s1_d[2*g]), .carry(s1_d[2*g+1])
    );
  end
  for (genvar k = 0; k < N0%3; k++) begin : g_l1_pass
    assign s1_d[2*(N0/3)+k] = pp[3*(N0/3)+k];
  end

  // S2: remaining tree levels, leaving exactly three rows.
  logic [P-1:0] s2_lvl  [L2+1][N1];
  logic [P-1:0] s2_rows [3];

  for (genvar r = 0; r < N1; r++) begin : g_l2_in
    assign s2_lvl[0][r] = s1_rows[r];
  end
  for (genvar l = 0; l < L2; l++) begin : g_l2
    localparam int C = rows_after(N1, l);
    localparam int G = C / 3;
    localparam int R = C % 3;
    for (genvar g = 0; g < G; g++) begin : g_csa
      wallace_csa_row #(.W(P)) u_csa (
        .x(s2_lvl[l][3*g]), .y(s2_lvl[l][3*g+1]), .z(s2_lvl[l][3*g+2]),
        .sum(s2_lvl[l+1][2*g]), .carry(s2_lvl[l+1][2*g+1])
      );
    end
    for (genvar k = 0; k < R; k++) begin : g_pass
      assign s2_lvl[l+1][2*G+k] = s2_lvl[l][3*G+k];
    end
    for (genvar z = 2*G+R; z < N1; z++) begin : g_zero
      assign s2_lvl[l+1][z] = '0;
    end
  end

  // S3: last 3:2 level.
  logic [P-1:0] s3_sum_d, s3_carry_d, s3_sum, s3_carry;

  wallace_csa_row #(.W(P)) u_csa_s3 (
    .x(s2_rows[0]), .y(s2_rows[1]), .z(s2_rows[2]),
    .sum(s3_sum_d), .carry(s3_carry_d)
  );

  // S4: optional accumulator fold, then Kogge-Stone carry-propagate add.
  logic [P-1:0] fa_x, fa_y, add_sum;

`ifdef WALLACE_ACC_EN
  logic [P-1:0] acc, addend;
  assign addend = s3_ctl.clr ? '0 : acc;
  wallace_csa_row #(.W(P)) u_csa_acc (
    .x(s3_sum), .y(s3_carry), .z(addend),
    .sum(fa_x), .carry(fa_y)
  );
`else
  assign fa_x = s3_sum;
  assign fa_y = s3_carry;
`endif

  always_comb begin
    logic [P-1:0] gk;
    logic [P-1:0] pk;
    gk = fa_x & fa_y;
    pk = fa_x ^ fa_y;
    for (int d = 1; d < P; d = d * 2) begin
      gk = gk | (pk & (gk << d));
      pk = pk & (pk << d);
    end
    add_sum = fa_x ^ fa_y ^ {gk[P-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N1; r++) s1_rows[r] <= '0;
      for (int r = 0; r < 3; r++) s2_rows[r] <= '0;
      s1_ctl    <= '0;
      s2_ctl    <= '0;
      s3_ctl    <= '0;
      s3_sum    <= '0;
      s3_carry  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
`ifdef WALLACE_ACC_EN
      acc       <= '0;
`endif
    end else if (adv) begin
      for (int r = 0; r < N1; r++) s1_rows[r] <= s1_d[r];
      for (int r = 0; r < 3; r++) s2_rows[r] <= s2_lvl[L2][r];
      s1_ctl    <= s1_ctl_d;
      s2_ctl    <= s1_ctl;
      s3_ctl    <= s2_ctl;
      s3_sum    <= s3_sum_d;
      s3_carry  <= s3_carry_d;
      out_valid <= s3_ctl.valid;
      if (s3_ctl.valid) begin
        out_data <= add_sum;
        out_tag  <= s3_ctl.tag[TAG_W-1:0];
`ifdef WALLACE_ACC_EN
        acc      <= add_sum;
`endif
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed and scoreboarded checks for wallace_mult_pipe (WIDTH=16, TAG_W=4).
module tb_wallace_mult_pipe;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam int NB = 60;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_signed;
  logic [TW-1:0] in_tag;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_data;
  logic [TW-1:0] out_tag;

  int total  = 0;
  int passed = 0;

  logic [2*W-1:0] exp_q[$];
  logic [TW-1:0]  tag_q[$];
  logic           was_stalled;
  logic [2*W-1:0] held_d;
  logic [TW-1:0]  held_t;
  int             sent;
  logic           seen;

  wallace_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] t, input logic clr);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t; acc_clr = clr;
    tick();
  endtask

  // Pre-edge evaluation for the streaming phase, then advance one clock.
  task automatic stream_step();
    #1;
    if (was_stalled) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, held_d);
      check("stall_tag", out_tag, held_t);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else begin
        check("stream_data", out_data, exp_q.pop_front());
        check("stream_tag", out_tag, tag_q.pop_front());
      end
    end
    was_stalled = out_valid && !out_ready;
    held_d = out_data;
    held_t = out_tag;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_a, in_b, in_signed));
      tag_q.push_back(in_tag);
      sent++;
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h5678; in_signed = 1'b0;
    in_tag = 4'h9; acc_clr = 1'b1; out_ready = 1'b1;
    was_stalled = 1'b0; held_d = '0; held_t = '0; sent = 0; seen = 1'b0;

    // Reset held two cycles with in_valid high.
    repeat (2) begin
      tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 32'h0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_data", out_data, 32'h0);

    // Unsigned max, latency boundary.
    beat(16'hFFFF, 16'hFFFF, 1'b0, 4'h3, 1'b1);
    in_valid = 1'b0;
    repeat (2) tick();
    check("lat_early", out_valid, 1'b0);
    tick();
    check("umax_valid", out_valid, 1'b1);
    check("umax_data", out_data, 32'hFFFE0001);
    check("umax_tag", out_tag, 4'h3);

    // Back-to-back signed/unsigned beats.
    beat(16'h8000, 16'h8000, 1'b1, 4'h5, 1'b1);
    beat(16'hFFFF, 16'h0002, 1'b1, 4'h6, 1'b1);
    beat(16'hFFFF, 16'h0002, 1'b0, 4'h7, 1'b1);
    in_valid = 1'b0;
    tick();
    check("smin_valid", out_valid, 1'b1);
    check("smin_data", out_data, 32'h40000000);
    check("smin_tag", out_tag, 4'h5);
    tick();
    check("sneg_data", out_data, 32'hFFFFFFFE);
    check("sneg_tag", out_tag, 4'h6);
    tick();
    check("umix_data", out_data, 32'h0001FFFE);
    check("umix_tag", out_tag, 4'h7);
    tick();
    check("idle_valid", out_valid, 1'b0);

    // Accumulator sequence (plain products when the accumulator is not built).
    beat(16'd3, 16'd4, 1'b0, 4'h1, 1'b1);
    beat(16'd5, 16'd6, 1'b0, 4'h2, 1'b0);
    beat(16'hFFFF, 16'hFFFF, 1'b1, 4'h3, 1'b0);
    in_valid = 1'b0; acc_clr = 1'b1;
    tick();
    check("acc0_data", out_data, 32'd12);
    tick();
`ifdef WALLACE_ACC_EN
    check("acc1_data", out_data, 32'd42);
    tick();
    check("acc2_data", out_data, 32'd43);
`else
    check("acc1_data", out_data, 32'd30);
    tick();
    check("acc2_data", out_data, 32'd1);
`endif
    check("acc2_tag", out_tag, 4'h3);
    tick();

    // Random stream with pseudo-random back-pressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = (sent < NB) && ($urandom_range(0, 3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = 1'($urandom_range(0, 1));
      in_tag    = TW'(sent);
      acc_clr   = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      stream_step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) stream_step();
    check("stream_sent", sent, NB);
    check("stream_drained", exp_q.size(), 0);

    // Reset with three beats in flight.
    beat(16'h0101, 16'h0202, 1'b0, 4'hA, 1'b1);
    beat(16'h0303, 16'h0404, 1'b1, 4'hB, 1'b1);
    beat(16'h0505, 16'h0606, 1'b0, 4'hC, 1'b1);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_data", out_data, 32'h0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", seen, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
